// File: rtl/trace_pkg.sv
// trace_pkg: shared types for the commit trace recorder.
// TRACE_TIMESTAMP_EN adds a cycle timestamp field to every trace entry.
package trace_pkg;

    localparam int TRACE_TS_W = 32;
    localparam int TRACE_XLEN = 32;

    typedef enum logic {
        REG = 1'b0,
        MEM = 1'b1
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e             kind;
        logic [4:0]              tag;
        logic [TRACE_XLEN-1:0]   addr;
        logic [TRACE_XLEN-1:0]   data;
`ifdef TRACE_TIMESTAMP_EN
        logic [TRACE_TS_W-1:0]   ts;
`endif
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: trace entry storage, two synchronous write ports, one asynchronous read port.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  trace_entry_t             wdata1,
    input  logic                     we2,
    input  logic [$clog2(DEPTH)-1:0] waddr2,
    input  trace_entry_t             wdata2,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output trace_entry_t             rdata
);

    trace_entry_t mem [DEPTH];

    // port 2 is written first so port 1 wins if the addresses ever matched
    always_ff @(posedge clk) begin
        if (we2) mem[waddr2] <= wdata2;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_recorder.sv
// commit_trace_recorder: circular trace of WB register commits and MEM writes with a hang watchdog.
// TRACE_TIMESTAMP_EN adds a free-running cycle counter stamped into every entry.
// XLEN must equal trace_pkg::TRACE_XLEN because the entry layout is fixed in the package.
module commit_trace_recorder
    import trace_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int XLEN      = TRACE_XLEN,
    parameter int TIMEOUT   = 10000,
    parameter int WRAP_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     freeze,
    input  logic                     rf_we,
    input  logic [4:0]               wr_idx,
    input  logic [XLEN-1:0]          rf_wd,
    input  logic [XLEN-1:0]          pc_wb,
    input  logic [3:0]               mem_we,
    input  logic [XLEN-1:0]          mem_addr,
    input  logic [XLEN-1:0]          mem_wdata,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output trace_entry_t             rd_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         lost_cnt,
    output logic                     hang
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOST_MAX = '1;

    logic [PW-1:0] wptr, rptr;
    logic [IW-1:0] idle, idle_next;
    logic [CW-1:0] free;
    logic [1:0]    n_ev, n_fit, n_lost, n_wr;
    logic          reg_ev, reg_push, mem_push, pop;
    trace_entry_t  reg_entry, mem_entry, head;

`ifdef TRACE_TIMESTAMP_EN
    logic [TRACE_TS_W-1:0] ts;

    // free-running capture clock; both entries of a pair see the same value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else ts <= clear ? '0 : ts + 1'b1;
    end
`endif

    // event decode, space after the same-cycle pop, and the entries offered to the RAM
    always_comb begin
        reg_ev = rf_we && wr_idx != 5'd0;
        reg_push = reg_ev && !freeze && !clear;
        mem_push = mem_we != 4'd0 && !freeze && !clear;
        pop = rd_valid && rd_ready;
        free = CW'(DEPTH) - count + CW'(pop);
        n_ev = 2'(reg_push) + 2'(mem_push);
        n_fit = CW'(n_ev) <= free ? n_ev : free[1:0];
        n_lost = n_ev - n_fit;
        n_wr = WRAP_MODE != 0 ? n_ev : n_fit;
        reg_entry = '0;
        reg_entry.kind = REG;
        reg_entry.tag = wr_idx;
        reg_entry.addr = pc_wb;
        reg_entry.data = rf_wd;
        mem_entry = '0;
        mem_entry.kind = MEM;
        mem_entry.tag = {1'b0, mem_we};
        mem_entry.addr = mem_addr;
        mem_entry.data = mem_wdata;
`ifdef TRACE_TIMESTAMP_EN
        reg_entry.ts = ts;
        mem_entry.ts = ts;
`endif
        idle_next = reg_ev ? '0 : idle == IW'(TIMEOUT) ? idle : idle + 1'b1;
    end

    // the reg entry always takes the first slot, the mem entry follows it
    trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .we1    (n_wr != 2'd0),
        .waddr1 (wptr),
        .wdata1 (reg_push ? reg_entry : mem_entry),
        .we2    (n_wr == 2'd2),
        .waddr2 (wptr + 1'b1),
        .wdata2 (mem_entry),
        .raddr  (rptr),
        .rdata  (head)
    );

    assign rd_valid = count != '0;
    assign rd_entry = rd_valid ? head : '0;

    // pointers and occupancy; in wrap mode entries that did not fit push the read pointer forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            lost_cnt <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            lost_cnt <= '0;
        end else begin
            wptr <= wptr + PW'(n_wr);
            rptr <= rptr + PW'(pop) + (WRAP_MODE != 0 ? PW'(n_lost) : PW'(0));
            count <= count - CW'(pop) + CW'(n_fit);
            lost_cnt <= lost_cnt > LOST_MAX - CNT_W'(n_lost) ? LOST_MAX : lost_cnt + CNT_W'(n_lost);
        end
    end

    // watchdog: idle cycles since the last reg event, frozen or not; hang is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle <= '0;
            hang <= 1'b0;
        end else if (clear) begin
            idle <= '0;
            hang <= 1'b0;
        end else begin
            idle <= idle_next;
            hang <= hang || idle_next == IW'(TIMEOUT);
        end
    end

endmodule

// File: tb/tb_commit_trace_recorder.sv
// tb_commit_trace_recorder: both wrap modes side by side against a queue-based reference model.
module tb_commit_trace_recorder;
    import trace_pkg::*;

    localparam int D    = 4;
    localparam int TO   = 8;
    localparam int CW   = 4;
    localparam int LMAX = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        freeze = 1'b0;
    logic        rf_we = 1'b0;
    logic [4:0]  wr_idx = '0;
    logic [31:0] rf_wd = '0;
    logic [31:0] pc_wb = '0;
    logic [3:0]  mem_we = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        rd_ready = 1'b0;

    logic          rd_valid0, rd_valid1, hang0, hang1;
    logic [2:0]    count0, count1;
    logic [CW-1:0] lost0, lost1;
    trace_entry_t  entry0, entry1;

    trace_entry_t q0[$];
    trace_entry_t q1[$];
    int m_lost0, m_lost1, m_idle;
    bit m_hang;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] m_ts;
`endif
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    commit_trace_recorder #(.DEPTH(D), .XLEN(32), .TIMEOUT(TO), .WRAP_MODE(0), .CNT_W(CW)) u_stop (
        .clk(clk), .rst_n(rst_n), .clear(clear), .freeze(freeze),
        .rf_we(rf_we), .wr_idx(wr_idx), .rf_wd(rf_wd), .pc_wb(pc_wb),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_entry(entry0),
        .count(count0), .lost_cnt(lost0), .hang(hang0)
    );

    commit_trace_recorder #(.DEPTH(D), .XLEN(32), .TIMEOUT(TO), .WRAP_MODE(1), .CNT_W(CW)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear), .freeze(freeze),
        .rf_we(rf_we), .wr_idx(wr_idx), .rf_wd(rf_wd), .pc_wb(pc_wb),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rd_valid(rd_valid1), .rd_ready(rd_ready), .rd_entry(entry1),
        .count(count1), .lost_cnt(lost1), .hang(hang1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_lost0 = 0;
        m_lost1 = 0;
        m_idle = 0;
        m_hang = 0;
`ifdef TRACE_TIMESTAMP_EN
        m_ts = '0;
`endif
    endtask

    // one clock of the reference: pop, then record events, then the watchdog
    task automatic model_step();
        trace_entry_t ev[$];
        trace_entry_t e;
        bit re;
        re = rf_we && wr_idx != 5'd0;
        if (q0.size() != 0 && rd_ready) void'(q0.pop_front());
        if (q1.size() != 0 && rd_ready) void'(q1.pop_front());
        if (clear) begin
            model_reset();
        end else begin
            if (!freeze && re) begin
                e = '0;
                e.kind = REG;
                e.tag = wr_idx;
                e.addr = pc_wb;
                e.data = rf_wd;
`ifdef TRACE_TIMESTAMP_EN
                e.ts = m_ts;
`endif
                ev.push_back(e);
            end
            if (!freeze && mem_we != 4'd0) begin
                e = '0;
                e.kind = MEM;
                e.tag = {1'b0, mem_we};
                e.addr = mem_addr;
                e.data = mem_wdata;
`ifdef TRACE_TIMESTAMP_EN
                e.ts = m_ts;
`endif
                ev.push_back(e);
            end
            foreach (ev[i]) begin
                if (q0.size() < D) q0.push_back(ev[i]);
                else m_lost0++;
                if (q1.size() == D) begin
                    void'(q1.pop_front());
                    m_lost1++;
                end
                q1.push_back(ev[i]);
            end
            if (m_lost0 > LMAX) m_lost0 = LMAX;
            if (m_lost1 > LMAX) m_lost1 = LMAX;
            m_idle = re ? 0 : (m_idle < TO ? m_idle + 1 : TO);
            if (m_idle == TO) m_hang = 1;
`ifdef TRACE_TIMESTAMP_EN
            m_ts = m_ts + 1;
`endif
        end
    endtask

    task automatic compare_all();
        trace_entry_t h0, h1;
        h0 = '0;
        h1 = '0;
        if (q0.size() != 0) h0 = q0[0];
        if (q1.size() != 0) h1 = q1[0];
        check("count_stop", 128'(count0), 128'(q0.size()));
        check("valid_stop", 128'(rd_valid0), 128'(q0.size() != 0));
        check("entry_stop", 128'(entry0), 128'(h0));
        check("lost_stop", 128'(lost0), 128'(m_lost0));
        check("hang_stop", 128'(hang0), 128'(m_hang));
        check("count_wrap", 128'(count1), 128'(q1.size()));
        check("valid_wrap", 128'(rd_valid1), 128'(q1.size() != 0));
        check("entry_wrap", 128'(entry1), 128'(h1));
        check("lost_wrap", 128'(lost1), 128'(m_lost1));
        check("hang_wrap", 128'(hang1), 128'(m_hang));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit re, input logic [4:0] idx, input logic [31:0] wd, input logic [31:0] pc,
                         input logic [3:0] mwe, input logic [31:0] ma, input logic [31:0] md, input bit rdy);
        rf_we = re;
        wr_idx = idx;
        rf_wd = wd;
        pc_wb = pc;
        mem_we = mwe;
        mem_addr = ma;
        mem_wdata = md;
        rd_ready = rdy;
        clear = 1'b0;
        freeze = 1'b0;
    endtask

    // asserts rst_n between edges and checks that everything clears without a clock
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_count_stop", 128'(count0), 128'd0);
        check("rst_valid_wrap", 128'(rd_valid1), 128'd0);
        check("rst_entry_wrap", 128'(entry1), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        drive(1, 5'd5, 32'h11, 32'h0, 4'h0, 0, 0, 0); cycle();
        drive(1, 5'd6, 32'h22, 32'h4, 4'h0, 0, 0, 0); cycle();
        drive(1, 5'd0, 32'h33, 32'h8, 4'h0, 0, 0, 0); cycle();
        check("t1_count", 128'(count0), 128'd2);
        check("t1_head", 128'(entry0.tag), 128'd5);
        drive(0, 5'd0, 0, 0, 4'h0, 0, 0, 1); cycle();
        check("t1_second", 128'(entry0.tag), 128'd6);
        cycle();
        check("t1_empty", 128'(rd_valid0), 128'd0);

        drive(1, 5'd1, 32'hA, 32'hC, 4'b0011, 32'h100, 32'hBEEF, 0); cycle();
        check("t2_count", 128'(count0), 128'd2);
        check("t2_first_kind", 128'(entry0.kind), 128'(REG));
        drive(0, 5'd0, 0, 0, 4'h0, 0, 0, 1); cycle();
        check("t2_second_kind", 128'(entry0.kind), 128'(MEM));
        check("t2_second_data", 128'(entry0.data), 128'h0000BEEF);
        check("t2_second_tag", 128'(entry0.tag), 128'd3);
        cycle();

        for (int i = 1; i <= 6; i++) begin
            drive(1, 5'(i), 32'(i * 16), 32'(i * 4), 4'h0, 0, 0, 0);
            cycle();
        end
        check("t3_count", 128'(count0), 128'd4);
        check("t3_lost", 128'(lost0), 128'd2);
        check("t3_head", 128'(entry0.tag), 128'd1);
        check("t4_count", 128'(count1), 128'd4);
        check("t4_lost", 128'(lost1), 128'd2);
        check("t4_head", 128'(entry1.tag), 128'd3);

        drive(1, 5'd7, 32'h70, 32'h1C, 4'h0, 0, 0, 1); cycle();
        check("t6_count", 128'(count0), 128'd4);
        check("t6_lost", 128'(lost0), 128'd2);
        check("t6_head", 128'(entry0.tag), 128'd2);
        check("t6_wrap_head", 128'(entry1.tag), 128'd4);

        drive(1, 5'd9, 32'h90, 32'h24, 4'hF, 32'h200, 32'h1234, 0); cycle();
        cycle();
        do_reset();

        drive(1, 5'd3, 32'h5, 32'h40, 4'h1, 32'h44, 32'h6, 0);
        freeze = 1'b1;
        cycle();
        check("frz_count", 128'(count0), 128'd0);

        drive(0, 5'd0, 0, 0, 4'h0, 0, 0, 0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        repeat (7) cycle();
        check("t5_hang_early", 128'(hang0), 128'd0);
        cycle();
        check("t5_hang_set", 128'(hang0), 128'd1);
        drive(1, 5'd2, 32'h1, 32'h50, 4'h0, 0, 0, 1); cycle();
        check("t5_hang_sticky", 128'(hang1), 128'd1);
        drive(0, 5'd0, 0, 0, 4'h0, 0, 0, 0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check("t5_hang_clear", 128'(hang0), 128'd0);

        for (int i = 0; i < 600; i++) begin
            bit sparse;
            sparse = (i / 60) % 2 == 1;
            rf_we = sparse ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
            wr_idx = 5'($urandom_range(0, 7));
            rf_wd = $urandom;
            pc_wb = $urandom;
            mem_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            mem_addr = $urandom;
            mem_wdata = $urandom;
            freeze = $urandom_range(0, 9) == 0;
            clear = $urandom_range(0, 49) == 0;
            rd_ready = $urandom_range(0, 2) == 0;
            cycle();
            if (i == 300) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
